// File: rtl/ps2_paddle_ctrl_if.sv
// Byte stream in, held-key state and paddle move pulses out.
// The master side (PS/2 receiver or bench) drives the scancode strobe and byte;
// the slave side (ps2_paddle_ctrl) drives the key state, pulses and pause.
interface ps2_paddle_ctrl_if;
    logic       byte_valid;
    logic [7:0] byte_data;
    logic [5:0] key_held;
    logic       p1_up;
    logic       p1_dn;
    logic       p2_up;
    logic       p2_dn;
    logic       pause;

    modport master (
        output byte_valid,
        output byte_data,
        input  key_held,
        input  p1_up,
        input  p1_dn,
        input  p2_up,
        input  p2_dn,
        input  pause
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output key_held,
        output p1_up,
        output p1_dn,
        output p2_up,
        output p2_dn,
        output pause
    );
endinterface

// File: rtl/ps2_paddle_ctrl.sv
// PS/2 scancode decoder for the Pong paddles.
// Tracks the E0/F0 prefixes to see makes and releases of W/S/O/K and the
// extended arrow keys, keeps a held-key vector and turns each player's
// direction into rate-limited one-cycle move pulses.
// Optional feature: define PAUSE_KEY_EN to make the space key toggle pause.
module ps2_paddle_ctrl #(
    parameter int REPEAT_CYCLES = 833_333,
    parameter int SEQ_TIMEOUT   = 50_000
) (
    input  logic             inclock,
    input  logic             resetn,
    ps2_paddle_ctrl_if.slave bus
);

    localparam logic [7:0]  CODE_EXT      = 8'hE0;
    localparam logic [7:0]  CODE_BRK      = 8'hF0;
    localparam logic [23:0] REPEAT_RELOAD = 24'(REPEAT_CYCLES - 1);
    localparam logic [23:0] SEQ_LAST      = 24'(SEQ_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_UP   = 2'd1,
        DIR_DN   = 2'd2
    } dir_t;

    // Key vector bit for a final scancode; zero for anything that is not one of our keys.
    function automatic logic [5:0] key_mask(input logic ext, input logic [7:0] code);
        logic [5:0] m;
        m = 6'b000000;
        if (!ext) begin
            case (code)
                8'h1D:   m = 6'b000001;  // W
                8'h1B:   m = 6'b000010;  // S
                8'h44:   m = 6'b000100;  // O
                8'h42:   m = 6'b001000;  // K
                default: m = 6'b000000;
            endcase
        end else begin
            case (code)
                8'h75:   m = 6'b010000;  // UP_ARROW
                8'h72:   m = 6'b100000;  // DN_ARROW
                default: m = 6'b000000;
            endcase
        end
        return m;
    endfunction

    // Conflicting or absent requests both mean no movement.
    function automatic dir_t dir_of(input logic up_req, input logic dn_req);
        dir_t d;
        case ({up_req, dn_req})
            2'b10:   d = DIR_UP;
            2'b01:   d = DIR_DN;
            default: d = DIR_NONE;
        endcase
        return d;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  key_held_q, key_held_d;
    logic [23:0] seq_cnt_q, seq_cnt_d;
    logic        seq_expired_s;
    dir_t        dir_s     [2];
    dir_t        dir_q     [2];
    logic [23:0] rep_cnt_q [2];
    logic [23:0] rep_cnt_d [2];
    logic [1:0]  up_q, up_d;
    logic [1:0]  dn_q, dn_d;
    logic        pause_s;

    // Prefix decoder: next state, key updates and the stale-prefix timeout.
    always_comb begin
        state_d       = state_q;
        key_held_d    = key_held_q;
        seq_cnt_d     = seq_cnt_q;
        seq_expired_s = (state_q != ST_IDLE) && (seq_cnt_q == SEQ_LAST);
        if (bus.byte_valid) begin
            // A byte arriving in the expiry cycle is still decoded in the current state.
            seq_cnt_d = 24'd0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.byte_data == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else if (bus.byte_data == CODE_BRK) begin
                        state_d = ST_BRK;
                    end else begin
                        key_held_d = key_held_q | key_mask(1'b0, bus.byte_data);
                    end
                end
                ST_EXT: begin
                    if (bus.byte_data == CODE_BRK) begin
                        state_d = ST_EXT_BRK;
                    end else if (bus.byte_data == CODE_EXT) begin
                        state_d = ST_EXT;
                    end else begin
                        key_held_d = key_held_q | key_mask(1'b1, bus.byte_data);
                        state_d    = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    key_held_d = key_held_q & ~key_mask(1'b0, bus.byte_data);
                    state_d    = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    key_held_d = key_held_q & ~key_mask(1'b1, bus.byte_data);
                    state_d    = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end else if (seq_expired_s) begin
            state_d   = ST_IDLE;
            seq_cnt_d = 24'd0;
        end else if (state_q != ST_IDLE) begin
            seq_cnt_d = seq_cnt_q + 24'd1;
        end else begin
            seq_cnt_d = 24'd0;
        end
    end

    // Requested direction per player from the registered key vector.
    always_comb begin
        dir_s[0] = dir_of(key_held_q[0], key_held_q[1]);
        dir_s[1] = dir_of(key_held_q[2] | key_held_q[4], key_held_q[3] | key_held_q[5]);
    end

    // Pulse generators: fire immediately on a new direction, then every REPEAT_CYCLES.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            up_d[p]      = 1'b0;
            dn_d[p]      = 1'b0;
            rep_cnt_d[p] = rep_cnt_q[p];
            if (pause_s || (dir_s[p] == DIR_NONE)) begin
                rep_cnt_d[p] = 24'd0;
            end else if ((dir_s[p] != dir_q[p]) || (rep_cnt_q[p] == 24'd0)) begin
                rep_cnt_d[p] = REPEAT_RELOAD;
                up_d[p]      = (dir_s[p] == DIR_UP);
                dn_d[p]      = (dir_s[p] == DIR_DN);
            end else begin
                rep_cnt_d[p] = rep_cnt_q[p] - 24'd1;
            end
        end
    end

    // State, key vector, counters and pulse outputs.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            key_held_q <= 6'b000000;
            seq_cnt_q  <= 24'd0;
            up_q       <= 2'b00;
            dn_q       <= 2'b00;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]     <= DIR_NONE;
                rep_cnt_q[p] <= 24'd0;
            end
        end else begin
            state_q    <= state_d;
            key_held_q <= key_held_d;
            seq_cnt_q  <= seq_cnt_d;
            up_q       <= up_d;
            dn_q       <= dn_d;
            for (int p = 0; p < 2; p++) begin
                dir_q[p]     <= dir_s[p];
                rep_cnt_q[p] <= rep_cnt_d[p];
            end
        end
    end

`ifdef PAUSE_KEY_EN
    localparam logic [7:0] CODE_SPACE = 8'h29;
    logic pause_q, pause_d;

    // Space make toggles pause; breaks and extended forms arrive in other states and are ignored.
    always_comb begin
        pause_d = pause_q;
        if (bus.byte_valid && (state_q == ST_IDLE) && (bus.byte_data == CODE_SPACE)) begin
            pause_d = ~pause_q;
        end else begin
            pause_d = pause_q;
        end
    end

    // Pause register.
    always_ff @(posedge inclock) begin
        if (!resetn) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_d;
        end
    end

    assign pause_s = pause_q;
`else
    assign pause_s = 1'b0;
`endif

    assign bus.key_held = key_held_q;
    assign bus.p1_up    = up_q[0];
    assign bus.p1_dn    = dn_q[0];
    assign bus.p2_up    = up_q[1];
    assign bus.p2_dn    = dn_q[1];
    assign bus.pause    = pause_s;

endmodule

// File: tb/tb_ps2_paddle_ctrl.sv
// Bench for ps2_paddle_ctrl: directed scenarios followed by random scancode
// traffic, every cycle compared against a prefix-flag / pulse-schedule model.
module tb_ps2_paddle_ctrl;

    localparam int R  = 16;
    localparam int TO = 20;

    logic inclock = 1'b0;
    logic resetn  = 1'b0;
    always #5 inclock = ~inclock;

    ps2_paddle_ctrl_if bus ();

    ps2_paddle_ctrl #(
        .REPEAT_CYCLES(R),
        .SEQ_TIMEOUT  (TO)
    ) dut (
        .inclock(inclock),
        .resetn (resetn),
        .bus    (bus)
    );

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [5:0] m_keys;
    bit         m_ext, m_brk, m_pause;
    int         m_last, t;
    int         dir_prev [2];
    int         next_fire[2];
    bit         exp_up   [2];
    bit         exp_dn   [2];

    function automatic logic [5:0] tb_key(input bit ext, input logic [7:0] c);
        logic [5:0] m;
        m = 6'b000000;
        if (!ext) begin
            if (c == 8'h1D) m = 6'b000001;
            else if (c == 8'h1B) m = 6'b000010;
            else if (c == 8'h44) m = 6'b000100;
            else if (c == 8'h42) m = 6'b001000;
        end else begin
            if (c == 8'h75) m = 6'b010000;
            else if (c == 8'h72) m = 6'b100000;
        end
        return m;
    endfunction

    // 0 = none, 1 = up, 2 = down
    function automatic int tb_dir(input logic [5:0] k, input int p);
        bit up, dn;
        up = (p == 0) ? k[0] : (k[2] | k[4]);
        dn = (p == 0) ? k[1] : (k[3] | k[5]);
        if (up && !dn) return 1;
        if (dn && !up) return 2;
        return 0;
    endfunction

    task automatic model_init();
        m_keys = 6'b000000;
        m_ext = 0; m_brk = 0; m_pause = 0;
        m_last = 0; t = 0;
        for (int p = 0; p < 2; p++) begin
            dir_prev[p] = 0; next_fire[p] = 0; exp_up[p] = 0; exp_dn[p] = 0;
        end
    endtask

    task automatic model_edge(input bit v, input logic [7:0] d);
        logic [5:0] mask;
        for (int p = 0; p < 2; p++) begin
            int  dir;
            bit  fire;
            dir  = tb_dir(m_keys, p);
            fire = 0;
            if (m_pause) begin
                next_fire[p] = t + 1;
            end else if (dir != 0) begin
                if (dir != dir_prev[p] || t == next_fire[p]) begin
                    fire = 1;
                    next_fire[p] = t + R;
                end
            end
            exp_up[p]   = fire && (dir == 1);
            exp_dn[p]   = fire && (dir == 2);
            dir_prev[p] = dir;
        end
        if (v) begin
            m_last = t;
            if (!m_brk && d == 8'hE0) begin
                m_ext = 1;
            end else if (!m_brk && d == 8'hF0) begin
                m_brk = 1;
            end else begin
`ifdef PAUSE_KEY_EN
                if (!m_ext && !m_brk && d == 8'h29) m_pause = !m_pause;
`endif
                mask = tb_key(m_ext, d);
                if (m_brk) m_keys = m_keys & ~mask;
                else       m_keys = m_keys | mask;
                m_ext = 0;
                m_brk = 0;
            end
        end else if ((m_ext || m_brk) && (t - m_last >= TO)) begin
            m_ext = 0;
            m_brk = 0;
        end
        t++;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic chk_all();
        chk("key_held", {2'b00, bus.key_held}, {2'b00, m_keys});
        chk("p1_up", {7'd0, bus.p1_up}, {7'd0, exp_up[0]});
        chk("p1_dn", {7'd0, bus.p1_dn}, {7'd0, exp_dn[0]});
        chk("p2_up", {7'd0, bus.p2_up}, {7'd0, exp_up[1]});
        chk("p2_dn", {7'd0, bus.p2_dn}, {7'd0, exp_dn[1]});
        chk("pause", {7'd0, bus.pause}, {7'd0, m_pause});
    endtask

    task automatic clk_step(input bit v, input logic [7:0] d);
        bus.byte_valid = v;
        bus.byte_data  = d;
        @(posedge inclock);
        model_edge(v, d);
        #1;
        chk_all();
    endtask

    task automatic send(input logic [7:0] d);
        clk_step(1'b1, d);
    endtask

    task automatic idle(input int n);
        repeat (n) clk_step(1'b0, 8'h00);
    endtask

    task automatic do_reset(input int n);
        resetn         = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (n) @(posedge inclock);
        #1;
        chk("rst_key_held", {2'b00, bus.key_held}, 8'h00);
        chk("rst_pulses", {4'd0, bus.p2_dn, bus.p2_up, bus.p1_dn, bus.p1_up}, 8'h00);
        chk("rst_pause", {7'd0, bus.pause}, 8'h00);
        model_init();
        resetn = 1'b1;
    endtask

    logic [7:0] pool [12];

    initial begin
        pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h44, 8'h42,
                 8'h75, 8'h72, 8'h29, 8'hE0, 8'hF0, 8'h1C};
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        model_init();
        do_reset(3);

        // W make: key set next cycle, p1_up at N+2 and every R cycles
        send(8'h1D);
        chk("w_make_lit", {2'b00, bus.key_held}, 8'h01);
        idle(1);
        chk("w_first_pulse_lit", {7'd0, bus.p1_up}, 8'h01);
        idle(R - 1);
        chk("w_gap_lit", {7'd0, bus.p1_up}, 8'h00);
        idle(1);
        chk("w_repeat_lit", {7'd0, bus.p1_up}, 8'h01);
        idle(20);
        send(8'hF0);
        send(8'h1D);
        chk("w_release_lit", {2'b00, bus.key_held}, 8'h00);
        idle(2 * R);

        // UP_ARROW plus O, release arrow, then release O
        send(8'hE0); send(8'h75); idle(5);
        send(8'h44); idle(20);
        send(8'hE0); send(8'hF0); send(8'h75); idle(2 * R + 3);
        send(8'hF0); send(8'h44); idle(R + 2);

        // W and S together cancel; releasing S starts p1_up
        send(8'h1D); send(8'h1B); idle(R + 4);
        send(8'hF0); send(8'h1B);
        idle(1);
        chk("s_release_up_lit", {7'd0, bus.p1_up}, 8'h01);
        idle(10);
        send(8'h1B); idle(5);                   // reverse towards S only once W goes
        send(8'hF0); send(8'h1D); idle(R + 3);
        send(8'hF0); send(8'h1B); idle(4);

        // Stale break prefix expires: following 1D is a make
        send(8'hF0); idle(TO + 3); send(8'h1D);
        chk("timeout_make_lit", {2'b00, bus.key_held}, 8'h01);
        idle(3);
        // Byte exactly in the expiry cycle is still a release
        send(8'hF0); idle(TO - 1); send(8'h1D);
        chk("expiry_cycle_release_lit", {2'b00, bus.key_held}, 8'h00);
        idle(3);
        // Extended prefix timing out, then exactly at the boundary
        send(8'hE0); idle(TO); send(8'h72); idle(2);
        send(8'h1D); idle(3); send(8'hE0); send(8'hF0); idle(TO); send(8'h1D); idle(3);

        // Keypad and extended aliases of mapped keys are ignored; repeated E0 stays extended
        send(8'h75); send(8'hE0); send(8'h1B); send(8'hE0); send(8'hE0); send(8'h72); idle(R + 2);
        send(8'hE0); send(8'hF0); send(8'h72); idle(3);
        send(8'h1D); send(8'h1D); send(8'h1D); idle(5);   // typematic repeat

        // Reset in the middle of a break sequence discards it
        send(8'hF0);
        do_reset(2);
        send(8'h1D);
        idle(4);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [7:0] b;
            int         gap;
            if ($urandom_range(0, 7) == 0) b = 8'($urandom_range(0, 255));
            else b = pool[$urandom_range(0, 11)];
            send(b);
            gap = ($urandom_range(0, 19) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 4);
            idle(gap);
        end
        idle(2 * R);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
